// File: rtl/ad_ip_jesd204_tpl_pkg.sv
// rtl/ad_ip_jesd204_tpl_pkg.sv - shared SOF-align FSM states and SOF position helper
package ad_ip_jesd204_tpl_pkg;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } sof_state_t;

  // Index of the lowest set flag; 0 when no flag is set.
  function automatic int lowest_set_bit(input logic [7:0] flags);
    int idx;
    idx = 0;
    for (int i = 7; i >= 0; i--) begin
      if (flags[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/ad_ip_jesd204_tpl_adc_sof_align_if.sv
// rtl/ad_ip_jesd204_tpl_adc_sof_align_if.sv - link-side beat stream and frame-aligned output stream
interface ad_ip_jesd204_tpl_adc_sof_align_if #(
  parameter int NUM_LANES       = 1,
  parameter int OCTETS_PER_BEAT = 4
);
  localparam int DW = OCTETS_PER_BEAT * 8 * NUM_LANES;

  logic                       link_valid;
  logic [OCTETS_PER_BEAT-1:0] link_sof;
  logic [DW-1:0]              link_data;
  logic                       out_valid;
  logic [OCTETS_PER_BEAT-1:0] out_sof;
  logic [DW-1:0]              out_data;

  modport master (
    output link_valid, link_sof, link_data,
    input  out_valid, out_sof, out_data
  );

  modport slave (
    input  link_valid, link_sof, link_data,
    output out_valid, out_sof, out_data
  );
endinterface

// File: rtl/ad_ip_jesd204_tpl_octet_shift.sv
// rtl/ad_ip_jesd204_tpl_octet_shift.sv - per-lane prev-beat register and octet realignment mux
module ad_ip_jesd204_tpl_octet_shift #(
  parameter int OCTETS_PER_BEAT = 4,
  parameter int OW              = 2
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         in_valid,
  input  logic [OCTETS_PER_BEAT*8-1:0] in_data,
  input  logic [OW-1:0]                offset,
  output logic [OCTETS_PER_BEAT*8-1:0] out_data
);
  localparam int DW = OCTETS_PER_BEAT * 8;

  logic [DW-1:0] cur;
  logic [DW-1:0] prev;
  logic          cur_valid;
  logic [DW-1:0] aligned;

  // Octet k of the output is octet (offset+k) of the two-beat stream {cur, prev}.
  assign aligned = DW'({cur, prev} >> {offset, 3'b000});

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cur       <= '0;
      cur_valid <= 1'b0;
      prev      <= '0;
      out_data  <= '0;
    end else begin
      cur       <= in_data;
      cur_valid <= in_valid;
      if (cur_valid) prev <= cur;
      out_data  <= aligned;
    end
  end
endmodule

// File: rtl/ad_ip_jesd204_tpl_adc_sof_align.sv
// rtl/ad_ip_jesd204_tpl_adc_sof_align.sv - JESD204 TPL ADC start-of-frame lock and octet realignment
module ad_ip_jesd204_tpl_adc_sof_align
  import ad_ip_jesd204_tpl_pkg::*;
#(
  parameter int NUM_LANES       = 1,
  parameter int OCTETS_PER_BEAT = 4,
  parameter int LOCK_COUNT      = 4,
  parameter int ERR_WIDTH       = 16
) (
  input  logic                               clk,
  input  logic                               resetn,
  ad_ip_jesd204_tpl_adc_sof_align_if.slave   bus,
  input  logic                               err_clear,
  output logic                               locked,
  output logic [$clog2(OCTETS_PER_BEAT)-1:0] align_offset,
  output logic [ERR_WIDTH-1:0]               err_count
);
  localparam int         OW = $clog2(OCTETS_PER_BEAT);
  localparam int         DW = OCTETS_PER_BEAT * 8;
  localparam logic [3:0] LC = 4'(LOCK_COUNT);

  sof_state_t state, state_nxt;
  logic [OW-1:0] cand, cand_nxt, off_nxt, pos, shift_off;
  logic [3:0]    cnt, cnt_nxt, cnt_inc;
  logic          miss, miss_nxt, err_inc, sof_beat;

  logic                       v1, v2;
  logic [OCTETS_PER_BEAT-1:0] sof_cur, sof_prev, sof_aligned, out_sof_q;

  assign sof_beat = bus.link_valid && (|bus.link_sof);
  assign pos      = OW'(lowest_set_bit(8'(bus.link_sof)));
  assign cnt_inc  = cnt + 4'd1;
  assign locked   = (state == ST_LOCKED);

  always_comb begin
    state_nxt = state;
    cand_nxt  = cand;
    cnt_nxt   = cnt;
    miss_nxt  = miss;
    off_nxt   = align_offset;
    err_inc   = 1'b0;
    if (sof_beat) begin
      case (state)
        ST_HUNT: begin
          cand_nxt = pos;
          cnt_nxt  = 4'd1;
          if (LOCK_COUNT == 1) begin
            off_nxt   = pos;
            state_nxt = ST_LOCKED;
          end else begin
            state_nxt = ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          if (pos == cand) begin
            cnt_nxt = cnt_inc;
            if (cnt_inc == LC) begin
              off_nxt   = cand;
              state_nxt = ST_LOCKED;
            end
          end else begin
            cand_nxt = pos;
            cnt_nxt  = 4'd1;
          end
        end
        ST_LOCKED: begin
          if (pos != align_offset) begin
            err_inc = 1'b1;
            // One stray SOF is tolerated; a second in a row means the frame moved.
            if (miss) begin
              miss_nxt  = 1'b0;
              state_nxt = ST_HUNT;
            end else begin
              miss_nxt = 1'b1;
            end
          end else begin
            miss_nxt = 1'b0;
          end
        end
        default: state_nxt = ST_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= ST_HUNT;
      cand         <= '0;
      cnt          <= '0;
      miss         <= 1'b0;
      align_offset <= '0;
      err_count    <= '0;
    end else begin
      state        <= state_nxt;
      cand         <= cand_nxt;
      cnt          <= cnt_nxt;
      miss         <= miss_nxt;
      align_offset <= off_nxt;
      if (err_clear) err_count <= '0;
      else if (err_inc && (err_count != '1)) err_count <= err_count + 1'b1;
    end
  end

  assign shift_off   = locked ? align_offset : '0;
  assign sof_aligned = OCTETS_PER_BEAT'({sof_cur, sof_prev} >> shift_off);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      sof_cur   <= '0;
      sof_prev  <= '0;
      out_sof_q <= '0;
    end else begin
      v1        <= bus.link_valid;
      v2        <= v1;
      sof_cur   <= bus.link_sof;
      if (v1) sof_prev <= sof_cur;
      out_sof_q <= sof_aligned;
    end
  end

  assign bus.out_sof   = out_sof_q;
  assign bus.out_valid = v2 & locked;

  for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
    ad_ip_jesd204_tpl_octet_shift #(
      .OCTETS_PER_BEAT(OCTETS_PER_BEAT),
      .OW             (OW)
    ) u_shift (
      .clk     (clk),
      .resetn  (resetn),
      .in_valid(bus.link_valid),
      .in_data (bus.link_data[n*DW +: DW]),
      .offset  (shift_off),
      .out_data(bus.out_data[n*DW +: DW])
    );
  end
endmodule

// File: tb/tb_ad_ip_jesd204_tpl_adc_sof_align.sv
// tb/tb_ad_ip_jesd204_tpl_adc_sof_align.sv - bench for SOF lock, realignment and error counting
module tb_ad_ip_jesd204_tpl_adc_sof_align;
  localparam int NL = 2, OPB = 4, LC = 4, EW = 6, DW = OPB * 8, MAXC = 8192;
  localparam int ERRMAX = (1 << EW) - 1;

  logic clk = 1'b0, resetn = 1'b0, err_clear = 1'b0;
  logic locked;
  logic [1:0] align_offset;
  logic [EW-1:0] err_count;

  ad_ip_jesd204_tpl_adc_sof_align_if #(.NUM_LANES(NL), .OCTETS_PER_BEAT(OPB)) bus ();

  ad_ip_jesd204_tpl_adc_sof_align #(
    .NUM_LANES(NL), .OCTETS_PER_BEAT(OPB), .LOCK_COUNT(LC), .ERR_WIDTH(EW)
  ) dut (
    .clk(clk), .resetn(resetn), .bus(bus), .err_clear(err_clear),
    .locked(locked), .align_offset(align_offset), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: beat history since reset plus the lock rules applied beat by beat.
  bit                hv[MAXC];
  logic [OPB-1:0]    hs[MAXC];
  logic [NL*DW-1:0]  hd[MAXC];
  bit                hl[MAXC];
  int                ho[MAXC];
  int cyc = 0, base = 0;
  int m_st, m_cand, m_cnt, m_miss, m_off, m_err;  // m_st: 0 hunt, 1 verify, 2 locked

  function automatic int lsb(input logic [OPB-1:0] s);
    for (int i = 0; i < OPB; i++) if (s[i]) return i;
    return 0;
  endfunction

  task automatic mdl_reset();
    m_st = 0; m_cand = 0; m_cnt = 0; m_miss = 0; m_off = 0; m_err = 0;
  endtask

  task automatic mdl_step(input bit v, input logic [OPB-1:0] sof, input bit clr);
    bit inc;
    int p;
    inc = 0;
    if (v && sof != 0) begin
      p = lsb(sof);
      if (m_st == 0) begin
        m_cand = p; m_cnt = 1;
        m_st = 1;
        if (m_cnt >= LC) begin m_off = p; m_st = 2; end
      end else if (m_st == 1) begin
        if (p == m_cand) m_cnt++;
        else begin m_cand = p; m_cnt = 1; end
        if (m_cnt >= LC) begin m_off = m_cand; m_st = 2; end
      end else if (p != m_off) begin
        inc = 1;
        if (m_miss != 0) begin m_st = 0; m_miss = 0; end
        else m_miss = 1;
      end else begin
        m_miss = 0;
      end
    end
    if (clr) m_err = 0;
    else if (inc && m_err < ERRMAX) m_err++;
  endtask

  task automatic expect_out(input int k, output bit ev, output logic [OPB-1:0] es,
                            output logic [NL*DW-1:0] ed);
    int j, off, idx;
    logic [NL*DW-1:0] cd, pd;
    logic [OPB-1:0] cs, ps;
    bit cv;
    j = k - 1;
    cd = '0; pd = '0; cs = '0; ps = '0; cv = 0; off = 0;
    if (j >= base) begin
      cd = hd[j]; cs = hs[j]; cv = hv[j];
      off = hl[j] ? ho[j] : 0;
      for (int p = j - 1; p >= base; p--) begin
        if (hv[p]) begin pd = hd[p]; ps = hs[p]; break; end
      end
    end
    ev = cv && hl[k];
    for (int o = 0; o < OPB; o++) begin
      idx = off + o;
      es[o] = (idx < OPB) ? ps[idx] : cs[idx-OPB];
      for (int n = 0; n < NL; n++) begin
        if (idx < OPB) ed[n*DW + o*8 +: 8] = pd[n*DW + idx*8 +: 8];
        else           ed[n*DW + o*8 +: 8] = cd[n*DW + (idx-OPB)*8 +: 8];
      end
    end
  endtask

  initial begin
    bit ev;
    logic [OPB-1:0] es;
    logic [NL*DW-1:0] ed;
    mdl_reset();
    forever begin
      @(posedge clk);
      if (!resetn) begin
        mdl_reset();
        base = cyc + 1;
      end else if (cyc < MAXC) begin
        hv[cyc] = bus.link_valid; hs[cyc] = bus.link_sof; hd[cyc] = bus.link_data;
        mdl_step(bus.link_valid, bus.link_sof, err_clear);
        hl[cyc] = (m_st == 2); ho[cyc] = m_off;
        expect_out(cyc, ev, es, ed);
        #1;
        check("out_valid", 64'(bus.out_valid), 64'(ev));
        check("out_sof", 64'(bus.out_sof), 64'(es));
        check("out_data", 64'(bus.out_data), 64'(ed));
        check("locked", 64'(locked), 64'(m_st == 2));
        check("align_offset", 64'(align_offset), 64'(m_off));
        check("err_count", 64'(err_count), 64'(m_err));
      end
      cyc++;
    end
  end

  function automatic logic [NL*DW-1:0] mkd(input int b);
    logic [DW-1:0] l0;
    for (int i = 0; i < OPB; i++) l0[i*8 +: 8] = 8'(b + i);
    return {~l0, l0};
  endfunction

  task automatic step(input bit v, input logic [OPB-1:0] sof, input logic [NL*DW-1:0] d,
                      input bit clr);
    bus.link_valid = v; bus.link_sof = sof; bus.link_data = d; err_clear = clr;
    @(posedge clk);
    #2;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_locked"}, 64'(locked), 64'd0);
    check({tag, "_offset"}, 64'(align_offset), 64'd0);
    check({tag, "_err"}, 64'(err_count), 64'd0);
    check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_out_sof"}, 64'(bus.out_sof), 64'd0);
    check({tag, "_out_data"}, 64'(bus.out_data), 64'd0);
  endtask

  task automatic do_reset(input string tag);
    resetn = 1'b0;
    #1;
    check_all_zero(tag);
    @(posedge clk);
    #2;
    resetn = 1'b1;
  endtask

  initial begin
    logic [OPB-1:0] s;
    int fav;
    bus.link_valid = 1'b0; bus.link_sof = '0; bus.link_data = '0;
    repeat (3) @(posedge clk);
    #2;
    check_all_zero("reset");
    resetn = 1'b1;

    // Lock on position 2 with SOF every second beat.
    step(1, 4'b0100, mkd(8'h80), 0);
    step(1, 4'b0000, mkd(8'h84), 0);
    step(1, 4'b0100, mkd(8'h88), 0);
    step(1, 4'b0000, mkd(8'h8c), 0);
    step(1, 4'b0100, mkd(8'h90), 0);
    step(1, 4'b0000, mkd(8'h94), 0);
    check("pre_lock", 64'(locked), 64'd0);
    step(1, 4'b0100, mkd(8'h00), 0);
    check("lock4", 64'(locked), 64'd1);
    check("lock4_offset", 64'(align_offset), 64'd2);
    step(1, 4'b0000, mkd(8'h04), 0);
    step(1, 4'b0100, mkd(8'h08), 0);
    check("aligned_sof", 64'(bus.out_sof), 64'h1);
    check("aligned_data", 64'(bus.out_data[31:0]), 64'h05040302);
    check("aligned_valid", 64'(bus.out_valid), 64'd1);

    // Single miss tolerated, two in a row drop lock.
    step(1, 4'b0010, mkd(8'h10), 0);
    check("miss1_err", 64'(err_count), 64'd1);
    check("miss1_locked", 64'(locked), 64'd1);
    step(1, 4'b0100, mkd(8'h14), 0);
    step(1, 4'b0010, mkd(8'h18), 0);
    step(1, 4'b1000, mkd(8'h1c), 0);
    check("miss2_locked", 64'(locked), 64'd0);
    check("miss2_valid", 64'(bus.out_valid), 64'd0);
    check("miss2_err", 64'(err_count), 64'd3);

    // Candidate restart in VERIFY.
    step(1, 4'b0010, mkd(8'h20), 0);
    step(1, 4'b0000, mkd(8'h24), 0);
    step(1, 4'b0010, mkd(8'h28), 0);
    step(1, 4'b1000, mkd(8'h2c), 0);
    step(1, 4'b1000, mkd(8'h30), 0);
    step(1, 4'b1000, mkd(8'h34), 0);
    check("restart_not_locked", 64'(locked), 64'd0);
    check("restart_offset_held", 64'(align_offset), 64'd2);
    step(1, 4'b1000, mkd(8'h38), 0);
    check("restart_locked", 64'(locked), 64'd1);
    check("restart_offset", 64'(align_offset), 64'd3);

    // Clear wins over increment, then saturation.
    step(1, 4'b0001, mkd(8'h3c), 1);
    check("clear_prio", 64'(err_count), 64'd0);
    step(1, 4'b1000, mkd(8'h40), 0);
    for (int i = 0; i < 70; i++) begin
      step(1, 4'b0001, mkd(i), 0);
      step(1, 4'b1000, mkd(i + 4), 0);
    end
    check("sat_err", 64'(err_count), 64'(ERRMAX));
    check("sat_locked", 64'(locked), 64'd1);
    step(1, 4'b0000, mkd(8'h50), 1);
    check("clear", 64'(err_count), 64'd0);

    // Reset while locked discards lock; four new SOF beats to relock.
    step(1, 4'b0001, mkd(8'h54), 0);
    #2;
    do_reset("midreset");
    for (int i = 0; i < 3; i++) step(1, 4'b1000, mkd(8'h60 + 4 * i), 0);
    check("relock3", 64'(locked), 64'd0);
    step(1, 4'b1000, mkd(8'h6c), 0);
    check("relock4", 64'(locked), 64'd1);
    check("relock_offset", 64'(align_offset), 64'd3);

    // Randomised traffic.
    fav = 1;
    for (int i = 0; i < 3000; i++) begin
      int r;
      if (i % 200 == 0) fav = $urandom_range(0, OPB - 1);
      r = $urandom_range(0, 9);
      if (r < 5) s = '0;
      else if (r < 8) s = OPB'(1 << fav);
      else s = OPB'($urandom_range(1, (1 << OPB) - 1));
      step($urandom_range(0, 3) != 0, s, {$urandom, $urandom}, $urandom_range(0, 49) == 0);
      if (i == 1500) do_reset("rnd_reset");
    end

    step(0, '0, '0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ad_ip_jesd204_tpl_adc_sof_align.md
AD_IP_JESD204_TPL_ADC_SOF_ALIGN -- requirements
Module: ad_ip_jesd204_tpl_adc_sof_align

Interface
REQ-001 SHALL have parameter NUM_LANES, default 1, number of link lanes.
REQ-002 SHALL have parameter OCTETS_PER_BEAT, default 4, octets per lane per beat; legal values are 4 and 8.
REQ-003 SHALL have parameter LOCK_COUNT, default 4, number of consecutive consistent SOF beats required to lock; legal range is 1..15.
REQ-004 SHALL have parameter ERR_WIDTH, default 16, width of the error counter.
REQ-005 SHALL have port clk, input, 1 bit, link clock (line-rate/40); the block uses one clock.
REQ-006 SHALL have port resetn, input, 1 bit, reset that is asynchronous and active-low.
REQ-007 SHALL have port link_valid, input, 1 bit, qualifies link_sof/link_data.
REQ-008 SHALL have port link_sof, input, OCTETS_PER_BEAT bits, start-of-frame flag per octet position, shared by all lanes.
REQ-009 SHALL have port link_data, input, OCTETS_PER_BEAT*8*NUM_LANES bits, lane n occupies bits [n*DW +: DW], where DW = OCTETS_PER_BEAT*8, and octet 0 is the LSB octet.
REQ-010 SHALL have port err_clear, input, 1 bit, synchronous clear of err_count.
REQ-011 SHALL have port out_valid, output, 1 bit, qualifies out_data.
REQ-012 SHALL have port out_sof, output, OCTETS_PER_BEAT bits, realigned SOF flags.
REQ-013 SHALL have port out_data, output, same width as link_data, frame-aligned data feeding the TPL deframer.
REQ-014 SHALL have port locked, output, 1 bit, high while the FSM is in LOCKED.
REQ-015 SHALL have port align_offset, output, clog2(OCTETS_PER_BEAT) bits, the applied octet offset.
REQ-016 SHALL have port err_count, output, ERR_WIDTH bits, saturating count of SOF-position mismatches seen while LOCKED.

Function
REQ-017 SOF position of a beat SHALL be the index of the lowest set bit of link_sof; a beat is an "SOF beat" only if link_valid=1 and link_sof!=0.
REQ-018 Beats with link_valid=0, or with link_valid=1 and link_sof=0, SHALL NOT change FSM state, counters or offset.
REQ-019 FSM states SHALL be HUNT, VERIFY and LOCKED.
REQ-020 In HUNT, an SOF beat SHALL capture its position into the candidate, set match count=1, and move to VERIFY; if LOCK_COUNT=1 the FSM SHALL move directly to LOCKED.
REQ-021 In VERIFY, an SOF beat at the candidate position SHALL increment the match count; on reaching LOCK_COUNT the FSM SHALL load align_offset with the candidate and move to LOCKED.
REQ-022 In VERIFY, an SOF beat at a different position SHALL replace the candidate and reset the match count to 1, staying in VERIFY.
REQ-023 In LOCKED, an SOF beat at a position different from align_offset SHALL increment err_count and set a miss flag; a second consecutive mismatching SOF beat SHALL move the FSM to HUNT.
REQ-024 In LOCKED, a matching SOF beat SHALL clear the miss flag.
REQ-025 err_count SHALL saturate at all-ones; err_clear SHALL zero it, and err_clear SHALL take priority over a simultaneous increment.
REQ-026 The block SHALL keep a per-lane register holding the previous valid beat (prev).
REQ-027 Per lane, output octet k SHALL equal stream octet (offset+k) of the concatenation {current beat, prev}: octets offset..OPB-1 come from prev, and octets 0..offset-1 come from current.
REQ-028 out_sof SHALL be derived from the SOF flags with the identical shift.
REQ-029 The shift SHALL use align_offset while LOCKED and 0 otherwise.
REQ-030 out_data and out_sof SHALL be registered; latency from input beat to output SHALL be 2 cycles, fixed for every offset.
REQ-031 out_valid SHALL be link_valid delayed 2 cycles AND'd with locked, both taken at that output cycle; data still flows with out_valid=0.
REQ-032 A LOCKED->HUNT transition SHALL drop locked and out_valid on the next cycle.
REQ-033 align_offset SHALL hold its value through HUNT/VERIFY until the next lock.

Reset
REQ-034 On resetn=0 the block SHALL asynchronously enter HUNT.
REQ-035 On resetn=0 the block SHALL zero locked, align_offset, err_count, out_valid, out_sof, out_data, prev, candidate, match count and miss flag.
REQ-036 Reset asserted mid-stream SHALL discard all history; after release, relocking SHALL require a full LOCK_COUNT sequence.

Structure
REQ-037 FSM state encoding and the lowest-set-bit function SHALL reside in a shared package, ad_ip_jesd204_tpl_pkg.
REQ-038 The per-lane prev register and shift mux SHALL be one sub-module, ad_ip_jesd204_tpl_octet_shift, instantiated NUM_LANES times; the FSM and counters SHALL be shared by all lanes.

Verification
REQ-039 OPB=4, LOCK_COUNT=4, SOF=4'b0100 on every 2nd valid beat -> locked=1 after the 4th SOF beat, align_offset=2, and out_sof=4'b0001.
REQ-040 Offset 2, lane data bytes 00,01,02.. in stream order -> out_data=32'h05040302 exactly 2 cycles later.
REQ-041 While locked, a single SOF at position 1 -> err_count=1 and locked stays 1; two consecutive mismatches -> locked=0, FSM in HUNT.
REQ-042 err_count forced to all-ones then a mismatch -> stays 16'hFFFF; err_clear asserted in the same cycle as an increment -> 0.
REQ-043 In VERIFY after 2 matches, an SOF at a new position -> match count restarts at 1; lock occurs 3 SOF beats later.
REQ-044 resetn pulsed low while LOCKED -> all outputs 0 immediately; relock requires 4 new SOF beats.
